// File: rtl/arb_pkg.sv
// Shared encodings for the 2:1 round-robin arbiter: FSM state and grant vectors.
package arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0    = 2'b01;
  localparam logic [1:0] GNT_1    = 2'b10;

  function automatic logic [1:0] gnt_of(input logic [1:0] st);
    case (st)
      ST_GNT0: gnt_of = GNT_0;
      ST_GNT1: gnt_of = GNT_1;
      default: gnt_of = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mux_2_1_w.sv
// W-wide behavioural 2:1 multiplexer used as the arbiter's shared datapath.
module mux_2_1_w #(
  parameter int W = 8
) (
  output logic [W-1:0] Y,
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
  input  logic         S
);

  assign Y = S ? I1 : I0;

endmodule

// File: rtl/arb_2_1_rr.sv
// Two-source round-robin arbiter with per-grant beat limit, driving a shared 2:1 mux.
module arb_2_1_rr
  import arb_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [1:0]   last,
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
  output logic [1:0]   gnt,
  output logic         S,
  output logic [W-1:0] Y,
  output logic         Y_valid
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          prio, prio_n;
  logic          S_n;
  logic          cur;
  logic          rel;

  // cur is the source owning the path; only meaningful in GNT0/GNT1
  assign cur = (state == ST_GNT1);
  assign rel = (req[cur] & last[cur])
             | (req[cur] & (cnt == CNT_LAST))
             | ~req[cur];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    prio_n  = prio;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (req == 2'b11)  state_n = prio ? ST_GNT1 : ST_GNT0;
        else if (req[0])   state_n = ST_GNT0;
        else if (req[1])   state_n = ST_GNT1;
      end
      ST_GNT0, ST_GNT1: begin
        if (rel) begin
          // last and forced release coinciding is a single release event
          prio_n = ~cur;
          cnt_n  = '0;
          if (req[~cur])     state_n = cur ? ST_GNT0 : ST_GNT1;
          else if (req[cur]) state_n = state;
          else               state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    S_n = S;
    if (state_n == ST_GNT0)      S_n = 1'b0;
    else if (state_n == ST_GNT1) S_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      prio  <= 1'b0;
      gnt   <= GNT_NONE;
      S     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      prio  <= prio_n;
      gnt   <= gnt_of(state_n);
      S     <= S_n;
    end
  end

  assign Y_valid = |(gnt & req);

  mux_2_1_w #(.W(W)) u_mux (
    .Y  (Y),
    .I0 (I0),
    .I1 (I1),
    .S  (S)
  );

endmodule

// File: tb/tb_arb_2_1_rr.sv
// Directed self-checking bench for arb_2_1_rr (W=8, MAX_BEATS=4).
module tb_arb_2_1_rr;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] last;
  logic [7:0] I0;
  logic [7:0] I1;
  logic [1:0] gnt;
  logic       S;
  logic [7:0] Y;
  logic       Y_valid;

  int unsigned total  = 0;
  int unsigned passed = 0;

  arb_2_1_rr #(.W(8), .MAX_BEATS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .last    (last),
    .I0      (I0),
    .I1      (I1),
    .gnt     (gnt),
    .S       (S),
    .Y       (Y),
    .Y_valid (Y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [1:0] g, input logic s,
                         input logic yv, input logic [7:0] y);
    chk({tag, ".gnt"}, {6'd0, gnt}, {6'd0, g});
    chk({tag, ".S"}, {7'd0, S}, {7'd0, s});
    chk({tag, ".Y_valid"}, {7'd0, Y_valid}, {7'd0, yv});
    chk({tag, ".Y"}, Y, y);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 2'b11; last = 2'b00; I0 = 8'h3C; I1 = 8'hA5;

    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("reset", 2'b00, 1'b0, 1'b0, 8'h3C);
    end

    // fairness: req=11, last=11 alternates every cycle starting with source 0
    rst = 1'b0; last = 2'b11;
    step(); chk_all("fair0", 2'b01, 1'b0, 1'b1, 8'h3C);
    step(); chk_all("fair1", 2'b10, 1'b1, 1'b1, 8'hA5);
    step(); chk_all("fair2", 2'b01, 1'b0, 1'b1, 8'h3C);
    step(); chk_all("fair3", 2'b10, 1'b1, 1'b1, 8'hA5);

    // withdraw in GNT1 -> IDLE, S holds 1, prio becomes 0
    req = 2'b00; #1;
    chk("wd1_valid", {7'd0, Y_valid}, 8'd0);
    step(); chk_all("wd1_idle", 2'b00, 1'b1, 1'b0, 8'hA5);

    // tie from IDLE goes to source 0
    req = 2'b11; last = 2'b00;
    step(); chk_all("tie_idle", 2'b01, 1'b0, 1'b1, 8'h3C);

    // source 0 ends with last while both request -> source 1 next, no bubble
    last = 2'b01;
    step(); chk_all("tie_svc", 2'b10, 1'b1, 1'b1, 8'hA5);
    req = 2'b00; last = 2'b00;
    step(); chk_all("tie_svc_idle", 2'b00, 1'b1, 1'b0, 8'hA5);

    // single requester, last on 3rd beat with req still high -> re-grant
    req = 2'b10;
    step(); chk_all("single_b1", 2'b10, 1'b1, 1'b1, 8'hA5);
    step(); chk_all("single_b2", 2'b10, 1'b1, 1'b1, 8'hA5);
    step(); chk_all("single_b3", 2'b10, 1'b1, 1'b1, 8'hA5);
    last = 2'b10;
    step(); chk_all("single_regnt", 2'b10, 1'b1, 1'b1, 8'hA5);
    req = 2'b00; last = 2'b00; #1;
    chk("single_novalid", {7'd0, Y_valid}, 8'd0);
    step(); chk_all("single_idle", 2'b00, 1'b1, 1'b0, 8'hA5);

    // forced release after 4 beats, re-grant with cnt cleared
    req = 2'b01;
    step(); chk_all("force_b1", 2'b01, 1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("force_bn", 2'b01, 1'b0, 1'b1, 8'h3C);
    end
    step(); chk_all("force_regnt", 2'b01, 1'b0, 1'b1, 8'h3C);
    // a fresh count must allow exactly 4 beats before handing over
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("force_cnt", 2'b01, 1'b0, 1'b1, 8'h3C);
    end
    step(); chk_all("force_hand", 2'b10, 1'b1, 1'b1, 8'hA5);

    // withdraw source 1 while source 0 requests -> GNT0 directly
    req = 2'b01; #1;
    chk("wd2_valid", {7'd0, Y_valid}, 8'd0);
    step(); chk_all("wd2_gnt0", 2'b01, 1'b0, 1'b1, 8'h3C);
    I0 = 8'h5A; #1;
    chk("data_track", Y, 8'h5A);
    req = 2'b00; #1;
    chk("wd3_valid", {7'd0, Y_valid}, 8'd0);
    step(); chk_all("wd3_idle", 2'b00, 1'b0, 1'b0, 8'h5A);

    // reset mid-burst
    req = 2'b10;
    step(); chk_all("rstmid_g", 2'b10, 1'b1, 1'b1, 8'hA5);
    step(); chk_all("rstmid_g2", 2'b10, 1'b1, 1'b1, 8'hA5);
    rst = 1'b1;
    step(); chk_all("rstmid", 2'b00, 1'b0, 1'b0, 8'h5A);
    rst = 1'b0; req = 2'b00;
    step(); chk_all("post_rst", 2'b00, 1'b0, 1'b0, 8'h5A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
